// File: rtl/clk_phase_gen_if.sv
// Phase-configuration handshake for clk_phase_gen.
// A requester (master) holds cfg_chan/cfg_phase stable with cfg_valid
// until a rising edge that also sees cfg_ready.
interface clk_phase_gen_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/clk_phase_gen.sv
// Multi-channel clock-phase generator in the refclk domain.
// One free-running master counter (period DIV) drives NUM_CLK one-cycle
// enable strobes, each at a runtime-programmable phase offset. 'locked'
// qualifies the strobes after reset and after every phase update.
// Optional macro CLK_PHASE_GEN_LEVEL_EN adds per-channel level clocks
// (outclk) that are high for ceil(DIV/2) cycles from each strobe.
module clk_phase_gen #(
  parameter int NUM_CLK     = 3,
  parameter int DIV         = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  clk_phase_gen_if.slave     cfg,
  output logic [NUM_CLK-1:0] outclk_en,
`ifdef CLK_PHASE_GEN_LEVEL_EN
  output logic [NUM_CLK-1:0] outclk,
`endif
  output logic               locked
);

  localparam int               LK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_LOCKING,
    ST_LOCKED,
    ST_UPDATE
  } state_t;

  state_t             state, state_n;
  logic [LK_W-1:0]    lock_cnt, lock_cnt_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   phase [NUM_CLK];
  logic [CNT_W-1:0]   phase_wr;
  logic               ready;
  logic               chan_ok;
  logic               accept;
  logic               run;
  logic [NUM_CLK-1:0] hit;

  assign cfg.cfg_ready = ready;
  assign locked        = (state == ST_LOCKED);

  // Out-of-range channels still complete the handshake but change nothing.
  assign chan_ok  = ({1'b0, cfg.cfg_chan} < (CH_W + 1)'(NUM_CLK));
  assign accept   = cfg.cfg_valid & ready & chan_ok;
  assign phase_wr = (cfg.cfg_phase > CNT_MAX) ? CNT_MAX : cfg.cfg_phase;

  // Strobes need LOCKED both now and next cycle, so an accept in LOCKED
  // cannot leak a strobe into the first unlocked cycle.
  assign run = (state == ST_LOCKED) && (state_n == ST_LOCKED);

  // Master phase counter: free-running, never realigned by configuration.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-channel phase registers, written (clamped) on a valid-channel accept.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CLK; i++) begin
        phase[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CLK; i++) begin
        if (accept && (cfg.cfg_chan == CH_W'(i))) begin
          phase[i] <= phase_wr;
        end
      end
    end
  end

  // Lock FSM state and lock counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Lock FSM next-state, lock counter and handshake ready.
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    ready      = 1'b0;
    case (state)
      ST_RESET: begin
        state_n    = ST_LOCKING;
        lock_cnt_n = '0;
      end
      ST_LOCKING: begin
        ready = 1'b1;
        if (accept) begin
          state_n    = ST_UPDATE;
          lock_cnt_n = '0;
        end else if (lock_cnt == LK_MAX) begin
          state_n = ST_LOCKED;
        end else begin
          lock_cnt_n = lock_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        ready = 1'b1;
        if (accept) begin
          state_n = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_n    = ST_LOCKING;
        lock_cnt_n = '0;
      end
      default: begin
        state_n    = ST_RESET;
        lock_cnt_n = '0;
      end
    endcase
  end

  // Phase match per channel, qualified by a stable lock.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CLK; i++) begin
      hit[i] = run && (cnt == phase[i]);
    end
  end

  // Registered strobes: one cycle after the counter match.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      outclk_en <= '0;
    end else begin
      outclk_en <= hit;
    end
  end

`ifdef CLK_PHASE_GEN_LEVEL_EN
  localparam int               HIGH    = (DIV + 1) / 2;
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH - 1);

  logic [CNT_W-1:0] hcnt [NUM_CLK];

  // Level clocks: rise with the strobe, hold HIGH cycles, drop on lock loss.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      outclk <= '0;
      for (int unsigned i = 0; i < NUM_CLK; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CLK; i++) begin
        if (state_n != ST_LOCKED) begin
          outclk[i] <= 1'b0;
        end else if (hit[i]) begin
          outclk[i] <= 1'b1;
          hcnt[i]   <= HI_LAST;
        end else if (outclk[i]) begin
          if (hcnt[i] == '0) begin
            outclk[i] <= 1'b0;
          end else begin
            hcnt[i] <= hcnt[i] - 1'b1;
          end
        end
      end
    end
  end
`else
  // Strobe-only build: no level clocks.
`endif

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed self-checking bench for clk_phase_gen (DIV=4, LOCK_CYCLES=16).
// With CLK_PHASE_GEN_LEVEL_EN defined a second DIV=5 instance checks outclk.
`timescale 1ns/1ps
module tb_clk_phase_gen;
  localparam int NUM_CLK     = 3;
  localparam int DIV         = 4;
  localparam int CNT_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = 2;

  logic               refclk = 1'b0;
  logic               rst_n  = 1'b0;
  logic [NUM_CLK-1:0] outclk_en;
  logic               locked;
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 exp_ph [NUM_CLK];

  clk_phase_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

`ifdef CLK_PHASE_GEN_LEVEL_EN
  logic [NUM_CLK-1:0] outclk;
  logic [NUM_CLK-1:0] en5;
  logic [NUM_CLK-1:0] outclk5;
  logic               locked5;

  clk_phase_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg5_if ();

  clk_phase_gen #(
    .NUM_CLK(NUM_CLK), .DIV(5), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES)
  ) u_dut5 (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg       (cfg5_if),
    .outclk_en (en5),
    .outclk    (outclk5),
    .locked    (locked5)
  );
`endif

  clk_phase_gen #(
    .NUM_CLK(NUM_CLK), .DIV(DIV), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES)
  ) u_dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg       (cfg_if),
    .outclk_en (outclk_en),
`ifdef CLK_PHASE_GEN_LEVEL_EN
    .outclk    (outclk),
`endif
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Counts edges until locked rises; flags any strobe seen while unlocked.
  task automatic wait_lock(output int n);
    bit bad;
    n   = 0;
    bad = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (locked !== 1'b1 && outclk_en !== '0) bad = 1'b1;
      if (locked === 1'b1) begin
        n = e;
        break;
      end
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL no_strobe_unlocked: observed strobe while locked=0, expected none");
    end
  endtask

  task automatic check_lock_len(input string name, input int n);
    n_cmp++;
    if (n !== LOCK_CYCLES + 1) begin
      n_bad++;
      $display("FAIL %s: observed %0d cycles to lock, expected %0d", name, n, LOCK_CYCLES + 1);
    end
  endtask

  // Captures 16 cycles and checks every channel against exp_ph, using ch0 as
  // timing reference. fresh=1 means sampling starts on the lock-entry cycle.
  task automatic check_pattern(input string name, input bit fresh);
    logic [NUM_CLK-1:0] smp [16];
    logic [NUM_CLK-1:0] expv;
    int t;
    int lo;
    smp[0] = outclk_en;
    for (int j = 1; j < 16; j++) begin
      tick();
      smp[j] = outclk_en;
    end
    if (fresh) begin
      n_cmp++;
      if (smp[0] !== '0) begin
        n_bad++;
        $display("FAIL %s_lock_edge: observed %0h, expected 0", name, smp[0]);
      end
    end
    t = -1;
    for (int j = 0; j < 16; j++) begin
      if (t < 0 && smp[j][0] === 1'b1) t = j;
    end
    lo = fresh ? 1 : 0;
    n_cmp++;
    if (t < lo || t > lo + DIV - 1) begin
      n_bad++;
      $display("FAIL %s_first_strobe: observed cycle %0d, expected %0d..%0d", name, t, lo, lo + DIV - 1);
      return;
    end
    for (int j = 0; j < 16; j++) begin
      expv = '0;
      for (int c = 0; c < NUM_CLK; c++) begin
        if ((!fresh || j >= 1) && ((j - t + exp_ph[0] - exp_ph[c] + 16 * DIV) % DIV == 0))
          expv[c] = 1'b1;
      end
      n_cmp++;
      if (smp[j] !== expv) begin
        n_bad++;
        $display("FAIL %s[%0d]: observed %b, expected %b", name, j, smp[j], expv);
      end
    end
  endtask

  task automatic do_write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] ph, input string name);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = ch;
    cfg_if.cfg_phase = ph;
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready_before: observed %b, expected 1", name, cfg_if.cfg_ready);
    end
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_update: observed locked=%b ready=%b, expected 0 0", name, locked, cfg_if.cfg_ready);
    end
  endtask

  task automatic check_all_low(input string name);
    n_cmp++;
    if (locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0 || outclk_en !== '0) begin
      n_bad++;
      $display("FAIL %s: observed locked=%b ready=%b en=%b, expected 0 0 000",
               name, locked, cfg_if.cfg_ready, outclk_en);
    end
`ifdef CLK_PHASE_GEN_LEVEL_EN
    n_cmp++;
    if (outclk !== '0) begin
      n_bad++;
      $display("FAIL %s_outclk: observed %b, expected 000", name, outclk);
    end
`endif
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge refclk);
    check_all_low("reset_state");
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL first_edge: observed ready=%b locked=%b, expected 1 0", cfg_if.cfg_ready, locked);
    end
    wait_lock(n);
    check_lock_len("reset_lock", n + 1);
  endtask

  task automatic test_lock();
    check_pattern("lock_aligned", 1'b1);
  endtask

  task automatic test_stagger();
    int n;
    do_write(2'd1, 8'd1, "w_ch1");
    wait_lock(n);
    check_lock_len("relock_ch1", n);
    exp_ph[1] = 1;
    do_write(2'd2, 8'd3, "w_ch2");
    wait_lock(n);
    check_lock_len("relock_ch2", n);
    exp_ph[2] = 3;
    check_pattern("stagger", 1'b1);
  endtask

  task automatic test_clamp();
    int n;
    do_write(2'd0, 8'd7, "w_clamp");
    wait_lock(n);
    check_lock_len("relock_clamp", n);
    exp_ph[0] = 3;
    check_pattern("clamp", 1'b1);
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'd0;
    cfg_if.cfg_phase = 8'd0;
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_k: observed %b, expected 1", cfg_if.cfg_ready);
    end
    tick();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_update_k: observed ready=%b locked=%b, expected 0 0", cfg_if.cfg_ready, locked);
    end
    cfg_if.cfg_chan  = 2'd2;
    cfg_if.cfg_phase = 8'd2;
    tick();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_k1: observed %b, expected 1", cfg_if.cfg_ready);
    end
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_update_k2: observed ready=%b locked=%b, expected 0 0", cfg_if.cfg_ready, locked);
    end
    wait_lock(n);
    check_lock_len("relock_b2b", n);
    exp_ph[0] = 0;
    exp_ph[2] = 2;
    check_pattern("b2b", 1'b1);
  endtask

  task automatic test_invalid_chan();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'd3;
    cfg_if.cfg_phase = 8'd1;
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL inval_ready: observed %b, expected 1", cfg_if.cfg_ready);
    end
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (locked !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL inval_no_relock: observed locked=%b ready=%b, expected 1 1", locked, cfg_if.cfg_ready);
    end
    check_pattern("inval_unchanged", 1'b0);
  endtask

  task automatic test_reset_mid_lock();
    int n;
    bit found;
    found = 1'b0;
    for (int e = 0; e < 8; e++) begin
      if (outclk_en !== '0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL strobe_seen: observed none in 8 cycles, expected a strobe");
    end
    #2 rst_n = 1'b0;
    #1 check_all_low("async_reset_locked");
    @(negedge refclk);
    rst_n = 1'b1;
    wait_lock(n);
    do_write(2'd1, 8'd2, "w_before_reset");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check_all_low("async_reset_locking");
    @(negedge refclk);
    rst_n = 1'b1;
    wait_lock(n);
    check_lock_len("relock_after_reset", n);
    for (int c = 0; c < NUM_CLK; c++) exp_ph[c] = 0;
    check_pattern("phases_cleared", 1'b1);
  endtask

`ifdef CLK_PHASE_GEN_LEVEL_EN
  task automatic test_level();
    logic s_en [20];
    logic s_oc [20];
    logic e_en;
    logic e_oc;
    int   t;
    bit   found;
    cfg5_if.cfg_valid = 1'b0;
    @(negedge refclk);
    rst_n = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int e = 0; e < 64; e++) begin
      tick();
      if (locked5 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL lvl_lock: observed no lock in 64 cycles, expected lock");
      return;
    end
    s_en[0] = en5[0];
    s_oc[0] = outclk5[0];
    for (int j = 1; j < 20; j++) begin
      tick();
      s_en[j] = en5[0];
      s_oc[j] = outclk5[0];
    end
    t = -1;
    for (int j = 0; j < 20; j++) begin
      if (t < 0 && s_en[j] === 1'b1) t = j;
    end
    n_cmp++;
    if (t < 1 || t > 5) begin
      n_bad++;
      $display("FAIL lvl_first_strobe: observed cycle %0d, expected 1..5", t);
      return;
    end
    for (int j = 0; j < 20; j++) begin
      e_en = (j >= 1) && ((j - t + 50) % 5 == 0);
      e_oc = (j >= t) && ((j - t) % 5 < 3);
      n_cmp++;
      if (s_en[j] !== e_en || s_oc[j] !== e_oc) begin
        n_bad++;
        $display("FAIL lvl[%0d]: observed en=%b outclk=%b, expected %b %b", j, s_en[j], s_oc[j], e_en, e_oc);
      end
    end
    found = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (outclk5[0] === 1'b1 && en5[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL lvl_rise_seen: observed none in 10 cycles, expected rise");
      return;
    end
    cfg5_if.cfg_valid = 1'b1;
    cfg5_if.cfg_chan  = 2'd0;
    cfg5_if.cfg_phase = 8'd0;
    tick();
    cfg5_if.cfg_valid = 1'b0;
    n_cmp++;
    if (outclk5[0] !== 1'b0 || locked5 !== 1'b0) begin
      n_bad++;
      $display("FAIL lvl_cut: observed outclk=%b locked=%b, expected 0 0", outclk5[0], locked5);
    end
  endtask
`endif

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_phase = '0;
`ifdef CLK_PHASE_GEN_LEVEL_EN
    cfg5_if.cfg_valid = 1'b0;
    cfg5_if.cfg_chan  = '0;
    cfg5_if.cfg_phase = '0;
`endif
    for (int c = 0; c < NUM_CLK; c++) exp_ph[c] = 0;
    test_reset();
    test_lock();
    test_stagger();
    test_clamp();
    test_back_to_back();
    test_invalid_chan();
    test_reset_mid_lock();
`ifdef CLK_PHASE_GEN_LEVEL_EN
    test_level();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised multi-channel clock-phase generator running entirely in the `refclk` domain. It produces `NUM_CLK` periodic clock-enable strobes that share one period of `DIV` refclk cycles, each at an independently programmable phase offset. A `locked` indication qualifies the outputs after reset and after every reconfiguration. It serves the CPU/video timing logic that needs phase-staggered enables without spending a hard PLL output per phase, and its phases can be retuned at runtime.

## Interface
- `NUM_CLK`, 3: number of output channels, 1..16.
- `DIV`, 4: refclk cycles per output period, 2..256.
- `CNT_W`, 8: width of the phase counter and the `cfg_phase` port; 2^CNT_W must be ≥ DIV.
- `LOCK_CYCLES`, 16: refclk cycles from entering LOCKING to `locked`=1; must be ≥ 1.
- `CH_W`, max(1, clog2(NUM_CLK)): derived; width of `cfg_chan`.

Ports:
- `refclk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cfg_valid`  in  1  phase-update request.
- `cfg_ready`  out  1  update can be accepted this cycle.
- `cfg_chan`  in  CH_W  channel to update; values ≥ NUM_CLK are accepted and ignored (no relock).
- `cfg_phase`  in  CNT_W  new phase offset in refclk cycles.
- `outclk_en`  out  NUM_CLK  one-cycle strobe per period, per channel.
- `outclk`  out  NUM_CLK  level clock per channel; present only with CLK_PHASE_GEN_LEVEL_EN.
- `locked`  out  1  outputs valid.

## Operation
- The master counter `cnt` runs 0..DIV-1 and wraps to 0. It runs free in every state except reset and is never realigned by configuration.
- Per-channel `phase[i]` registers reset to 0.
- FSM states:
  - RESET: entered asynchronously while `rst_n`=0.
  - LOCKING: entered on the first edge after `rst_n` rises; the lock counter starts at 0. Moves to LOCKED when the lock counter reaches LOCK_CYCLES-1.
  - LOCKED.
  - UPDATE: lasts exactly one cycle, then goes to LOCKING with the lock counter cleared.
- `cfg_ready`=1 in LOCKING and LOCKED, and 0 in RESET and UPDATE.
- Handshake:
  - A transfer occurs when `cfg_valid`=1 and `cfg_ready`=1 at a rising edge.
  - The requester must hold `cfg_chan` and `cfg_phase` stable until the transfer.
- Phase write on a valid channel:
  - The write `phase[cfg_chan]` = min(cfg_phase, DIV-1) is performed at the accept edge; out-of-range values are clamped, not wrapped.
  - The FSM enters UPDATE.
  - If the transfer is accepted in LOCKING, the lock count restarts.
- A transfer to an invalid channel completes the handshake with no state change.
- `outclk_en[i]` is registered: it is 1 in the cycle after an edge at which `cnt`==`phase[i]` and the FSM was in LOCKED. Otherwise it is 0.
- All strobes are suppressed whenever `locked`=0, so there are no partial periods around a relock.
- Channels with equal phase strobe in the same cycle.

## Timing
- Reset values: `cfg_ready`=0, `locked`=0, `outclk_en`=0, `outclk`=0, `cnt`=0, all phases 0. Outputs clear asynchronously on `rst_n` falling.
- After `rst_n` rises:
  - `cfg_ready`=1 after the first edge.
  - `locked`=1 after edge number LOCK_CYCLES+1.
  - The first strobe appears on a later edge, one cycle after the next `cnt`==phase match.
- Accept at edge k:
  - `locked`=0 and `cfg_ready`=0 from edge k.
  - `cfg_ready`=1 from edge k+1.
  - `locked`=1 from edge k+1+LOCK_CYCLES.
- Strobe latency: one refclk cycle after the `cnt` match. Strobe period is exactly DIV cycles.
- Reset mid-operation: the FSM returns to RESET immediately, any pending transfer is dropped, and phases are lost.

## Configuration
- CLK_PHASE_GEN_LEVEL_EN defined:
  - Adds the `outclk` port.
  - `outclk[i]` rises together with `outclk_en[i]` and stays high for ceil(DIV/2) cycles, then low for the remainder of the period.
  - `outclk` is forced 0 whenever `locked`=0. A high phase cut off by lock loss ends immediately.
- Macro undefined: the `outclk` port and its counters are absent; strobe behaviour is identical in both builds.

## Test plan
- Reset and lock (DIV=4, LOCK_CYCLES=16):
  - Stimulus: release `rst_n`.
  - Required: `locked` rises after edge 17; `outclk_en`=3'b111 once every 4 cycles thereafter, with no strobes before `locked`.
- Phase stagger:
  - Stimulus: write ch1=1, then ch2=3.
  - Required: each accept drops `locked` for 17 cycles. Afterwards `outclk_en[1]` is 1 cycle after `outclk_en[0]` and `outclk_en[2]` is 3 cycles after it, with period 4 on all channels.
- Clamp:
  - Stimulus: `cfg_phase`=7 on ch0 with DIV=4.
  - Required: phase stored as 3, so the ch0 strobe lands 3 cycles after a phase-0 channel.
- Handshake boundaries:
  - Stimulus: hold `cfg_valid` high across two back-to-back requests; separately, write to `cfg_chan`=3.
  - Required: back-to-back requests are accepted at edges k and k+2, because `cfg_ready`=0 during UPDATE. The `cfg_chan`=3 write is accepted, and `locked` stays 1.
- Reset mid-lock:
  - Stimulus: assert `rst_n` low during LOCKING.
  - Required: all outputs 0 without waiting for an edge; after release, phases read back as 0 (all strobes aligned).
- CLK_PHASE_GEN_LEVEL_EN with DIV=5:
  - Required: `outclk[0]` is high 3 cycles and low 2, and is aligned to `outclk_en[0]`.
